// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary to BCD converter (shift-and-add-3).
//
// A value is accepted in IDLE, converted one bit per clock in SHIFT, and the
// result is held in DONE until the consumer takes it.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   binary     value to convert, sampled only on the accept edge
//   in_valid   binary is valid
//   in_ready   block can accept (high only in IDLE)
//   bcd        result, digit k at bits [4k+3:4k], digit 0 = ones
//   sign       result is negative (always 0 unless BCD_SIGNED_EN)
//   out_valid  bcd/sign hold a completed result (DONE)
//   out_ready  consumer takes the result
//   busy       conversion in progress (SHIFT)
//
// Optional feature macro: BCD_SIGNED_EN -- treats binary as two's complement,
// converts its magnitude and reports the sign separately.

module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      binary,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Refuse to build a converter whose digits cannot hold the largest input.
   generate
      if (pow10(DIGITS) < (64'd1 << WIDTH)) begin : g_digits_too_few
         $error("bin2bcd_seq: DIGITS too small for WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       sr_q, sr_d;
   logic [4*DIGITS-1:0]    dig_q, dig_d;
   logic [4*DIGITS-1:0]    bcd_q, bcd_d;
   logic [4*DIGITS-1:0]    adj;
   logic [4*DIGITS-1:0]    dig_shifted;
   logic [WIDTH-1:0]       magnitude;

`ifdef BCD_SIGNED_EN
   logic                   sign_q, sign_d;
   logic                   sign_w_q, sign_w_d;

   // Two's complement magnitude; the most negative value maps onto its own
   // bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
   assign magnitude = binary[WIDTH-1] ? (~binary + WIDTH'(1)) : binary;
   assign sign      = sign_q;
`else
   assign magnitude = binary;
   assign sign      = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT);
   assign out_valid = (state_q == DONE);
   assign bcd       = bcd_q;

   // Add-3 correction: any digit of 5 or more would overflow past 9 once
   // doubled by the shift, so it is pre-biased into the next BCD decade.
   always_comb begin
      adj = dig_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Digits and shift register form one left-shifting chain.
   assign dig_shifted = {adj[4*DIGITS-2:0], sr_q[WIDTH-1]};

   // Next-state and datapath.  The published result only changes on the
   // final shift, so bcd never shows a partially converted value.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      dig_d    = dig_q;
      bcd_d    = bcd_q;
`ifdef BCD_SIGNED_EN
      sign_d   = sign_q;
      sign_w_d = sign_w_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = magnitude;
               dig_d   = '0;
               cnt_d   = CW'(WIDTH);
`ifdef BCD_SIGNED_EN
               sign_w_d = binary[WIDTH-1];
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            dig_d = dig_shifted;
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = dig_shifted;
`ifdef BCD_SIGNED_EN
               sign_d  = sign_w_q;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything so an aborted conversion
   // leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sr_q     <= '0;
         dig_q    <= '0;
         bcd_q    <= '0;
`ifdef BCD_SIGNED_EN
         sign_q   <= 1'b0;
         sign_w_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         dig_q    <= dig_d;
         bcd_q    <= bcd_d;
`ifdef BCD_SIGNED_EN
         sign_q   <= sign_d;
         sign_w_q <= sign_w_d;
`endif
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- directed bench for bin2bcd_seq.
// Two instances: 8-bit/3-digit and 16-bit/5-digit, sharing clock and reset.

module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;

   logic [7:0]  a_binary;
   logic        a_in_valid, a_in_ready, a_sign, a_out_valid, a_out_ready, a_busy;
   logic [11:0] a_bcd;

   logic [15:0] b_binary;
   logic        b_in_valid, b_in_ready, b_sign, b_out_valid, b_out_ready, b_busy;
   logic [19:0] b_bcd;

   int          checks;
   int          errors;
   logic [11:0] lastBcd;
   logic        lastSign;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .binary(a_binary), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .bcd(a_bcd), .sign(a_sign), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .busy(a_busy)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
      .clk(clk), .rst_n(rst_n), .binary(b_binary), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .bcd(b_bcd), .sign(b_sign), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .busy(b_busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Offer one value to the 8-bit instance and hold it until the accept edge.
   // Called at a falling edge; returns just after the accept edge with the
   // input scrambled to prove it is not re-sampled.
   task automatic applyStimulus(input logic [7:0] v);
      int waited;
      waited = 0;
      while (!a_in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!a_in_ready) begin
         checkOutput("accept_timeout", 32'(a_in_ready), 32'd1);
         return;
      end
      a_binary   = v;
      a_in_valid = 1'b1;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      a_binary   = ~v;
   endtask

   // Full conversion on the 8-bit instance: latency, result, optional stall
   // with out_ready low, then handshake and retention.
   task automatic convert8(input logic [7:0] v, input logic [11:0] expBcd,
                           input logic expSign, input int holdCycles);
      logic stable;
      applyStimulus(v);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 4) begin
            checkOutput("busy_mid", 32'(a_busy), 32'd1);
            checkOutput("bcd_hold_shift", 32'(a_bcd), 32'(lastBcd));
         end
         if (k == 7) begin
            checkOutput("early_valid", 32'(a_out_valid), 32'd0);
         end
      end
      checkOutput("out_valid", 32'(a_out_valid), 32'd1);
      checkOutput("bcd", 32'(a_bcd), 32'(expBcd));
      checkOutput("sign", 32'(a_sign), 32'(expSign));
      checkOutput("in_ready_done", 32'(a_in_ready), 32'd0);
      checkOutput("busy_done", 32'(a_busy), 32'd0);
      stable = 1'b1;
      for (int c = 0; c < holdCycles; c++) begin
         a_in_valid = 1'b1;
         a_binary   = 8'(c);
         @(posedge clk);
         @(negedge clk);
         if (a_bcd !== expBcd || a_in_ready !== 1'b0 || a_out_valid !== 1'b1 ||
             a_sign !== expSign) begin
            stable = 1'b0;
         end
      end
      a_in_valid = 1'b0;
      if (holdCycles > 0) begin
         checkOutput("hold_stable", 32'(stable), 32'd1);
      end
      a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_out_ready = 1'b0;
      checkOutput("valid_after_hs", 32'(a_out_valid), 32'd0);
      checkOutput("in_ready_after_hs", 32'(a_in_ready), 32'd1);
      checkOutput("bcd_retained", 32'(a_bcd), 32'(expBcd));
      lastBcd  = expBcd;
      lastSign = expSign;
   endtask

   // Full conversion on the 16-bit instance with exact latency check.
   task automatic convert16(input logic [15:0] v, input logic [19:0] expBcd,
                            input logic expSign);
      b_binary   = v;
      b_in_valid = 1'b1;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_binary   = 16'h0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 15) begin
            checkOutput("w16_early_valid", 32'(b_out_valid), 32'd0);
         end
      end
      checkOutput("w16_out_valid", 32'(b_out_valid), 32'd1);
      checkOutput("w16_bcd", 32'(b_bcd), 32'(expBcd));
      checkOutput("w16_sign", 32'(b_sign), 32'(expSign));
      b_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_out_ready = 1'b0;
      checkOutput("w16_in_ready_after_hs", 32'(b_in_ready), 32'd1);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      lastBcd     = 12'h000;
      lastSign    = 1'b0;
      a_binary    = 8'h00;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      b_binary    = 16'h0000;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      rst_n       = 1'b0;

      // Reset state is visible before any clock edge.
      #3;
      checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("rst_bcd", 32'(a_bcd), 32'd0);
      checkOutput("rst_sign", 32'(a_sign), 32'd0);
      checkOutput("rst_busy", 32'(a_busy), 32'd0);
      checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
      checkOutput("rst_w16_bcd", 32'(b_bcd), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

`ifdef BCD_SIGNED_EN
      convert8(8'h80, 12'h128, 1'b1, 0);
      convert8(8'hFF, 12'h001, 1'b1, 0);
      convert8(8'h7F, 12'h127, 1'b0, 0);
      convert8(8'd0,  12'h000, 1'b0, 0);
      convert8(8'd99, 12'h099, 1'b0, 0);
      convert8(8'd137, 12'h119, 1'b1, 20);
`else
      convert8(8'd255, 12'h255, 1'b0, 0);
      convert8(8'd0,   12'h000, 1'b0, 0);
      convert8(8'd99,  12'h099, 1'b0, 0);
      convert8(8'd137, 12'h137, 1'b0, 20);
`endif
      convert8(8'd9,   12'h009, 1'b0, 0);
      convert8(8'd10,  12'h010, 1'b0, 0);
      convert8(8'd100, 12'h100, 1'b0, 0);

`ifdef BCD_SIGNED_EN
      convert16(16'hFFFF, 20'h00001, 1'b1);
`else
      convert16(16'hFFFF, 20'h65535, 1'b0);
`endif
      convert16(16'd1000, 20'h01000, 1'b0);

      // Reset in the middle of a conversion clears everything at once.
      applyStimulus(8'd200);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("abort_bcd", 32'(a_bcd), 32'd0);
      checkOutput("abort_busy", 32'(a_busy), 32'd0);
      checkOutput("abort_in_ready", 32'(a_in_ready), 32'd1);
      checkOutput("abort_w16_bcd", 32'(b_bcd), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      lastBcd = 12'h000;
      convert8(8'd42, 12'h042, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
